ddc_pkt_arbiter: RTL

Packet-level round-robin arbiter that merges up to `N_CH` 128-bit DDC output streams into a single AXI4-Stream toward the DMA.
- Each packet is a fixed number of beats set by `packet_length`.
- The block generates `m_axis_tlast` on the final beat and tags every beat with the source channel ID.
- Once a channel is granted it keeps the output for a whole packet. Packets are never interleaved.

---
 rtl/ddc_pkt_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/ddc_pkt_arbiter.sv
// Packet-level round-robin arbiter merging N_CH 128-bit DDC streams into one
// AXI4-Stream; a granted channel owns the output for a whole packet.
module ddc_pkt_arbiter #(
  parameter int N_CH    = 4,
  parameter int C_WIDTH = 32
) (
  input  logic                  s_axis_aclk,
  input  logic                  s_axis_areset,
  input  logic [C_WIDTH-1:0]    packet_length,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH*128-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0]       s_axis_tvalid,
  output logic [N_CH-1:0]       s_axis_tready,
  output logic [127:0]          m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [3:0]            m_axis_tuser,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [3:0]         grant;
  logic [3:0]         last_grant;
  logic [C_WIDTH-1:0] len_q;
  logic [C_WIDTH-1:0] counter;

  logic [N_CH-1:0]    cand;
  logic               found_hi;
  logic               found_lo;
  logic [3:0]         win_hi;
  logic [3:0]         win_lo;
  logic               arb_found;
  logic [3:0]         arb_winner;
  logic               last_cnt;
  logic               beat_accept;

  // Rotating priority: the first candidate above last_grant wins, otherwise
  // the lowest-numbered candidate (the wrap-around part of the search).
  always_comb begin
    cand     = s_axis_tvalid & ch_enable;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found_hi && cand[k] && (4'(k) > last_grant)) begin
        found_hi = 1'b1;
        win_hi   = 4'(k);
      end
      if (!found_lo && cand[k]) begin
        found_lo = 1'b1;
        win_lo   = 4'(k);
      end
    end
    arb_found  = found_hi | found_lo;
    arb_winner = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == BURST) begin
      for (int k = 0; k < N_CH; k++) begin
        if (grant == 4'(k)) begin
          m_axis_tdata     = s_axis_tdata[k*128 +: 128];
          m_axis_tvalid    = s_axis_tvalid[k];
          s_axis_tready[k] = m_axis_tready;
        end
      end
    end
  end

  assign busy         = (state == BURST);
  assign m_axis_tuser = busy ? grant : 4'd0;
  assign last_cnt     = (counter == (len_q - C_WIDTH'(1)));
  assign m_axis_tlast = busy & last_cnt & m_axis_tvalid;
  assign beat_accept  = m_axis_tvalid & m_axis_tready;

  // len_q is captured at grant so mid-packet packet_length changes only
  // apply to the next packet; a zero length is treated as one beat.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= 4'(N_CH - 1);
      len_q      <= C_WIDTH'(1);
      counter    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant      <= arb_winner;
            last_grant <= arb_winner;
            len_q      <= (packet_length == '0) ? C_WIDTH'(1) : packet_length;
            counter    <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat_accept) begin
            if (last_cnt) begin
              counter <= '0;
              state   <= IDLE;
            end else begin
              counter <= counter + C_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
